print_output_arbiter_n: RTL
===========================

# print_output_arbiter_n

Parametrised successor to the single-core print output arbiter. It accepts hex-print requests from `NUM_CORES` cores and serves them round-robin. Accepted words are buffered in a `FIFO_DEPTH`-entry queue, each tagged with the originating core ID. The queue drains toward `chip_controller` under a valid/ack handshake, so a slow consumer stalls cores only once the queue is full. It sits between the core array and `chip_controller`, in the slot the single-core output arbiter occupies.

## Interface
- `NUM_CORES`, default 2: number of requesting cores, ≥1.
- `DATA_W`, default 32: print word width.
- `FIFO_DEPTH`, default 4: queue entries; must be a power of two, ≥2.
- `ID_W` (localparam): `max(1, $clog2(NUM_CORES))`.
- `CNT_W` (localparam): `$clog2(FIFO_DEPTH+1)`.
- `clk`, input, 1: system clock (the `clk` net from `chip_controller`); all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_core`, input, NUM_CORES: per-core print request level; held until that core's `is_ready_core` pulse.
- `data_core`, input, NUM_CORES*DATA_W: flattened per-core print data; core i occupies bits `[i*DATA_W +: DATA_W]`; stable while `req_core[i]` is high.
- `is_ready_core`, output, NUM_CORES: one-cycle pulse meaning "your word was accepted".
- `print_hex_enable`, output, 1: queue head valid.
- `print_output`, output, DATA_W: queue head data.
- `print_core_id`, output, ID_W: core index of the queue head.
- `print_ack`, input, 1: consumer takes the head this cycle.
- `fifo_level`, output, CNT_W: current occupancy.

## Operation
- Eligibility: `elig = req_core & ~is_ready_core`. A core is masked in its own ack cycle so that a still-high `req_core` cannot be double-accepted.
- Round-robin pointer `last_grant`, reset value `NUM_CORES-1` (core 0 has first priority).
- Priority order each cycle: `last_grant+1, last_grant+2, …` modulo `NUM_CORES`.
- Grant condition: any `elig` bit set and `fifo_level < FIFO_DEPTH`.
- On a grant to core g:
  - push `{g, data_core[g]}` into the queue;
  - set `last_grant <= g`;
  - `is_ready_core[g] <= 1` for exactly the next cycle.
- No grant: `last_grant` holds and all `is_ready_core` bits are 0 next cycle.
- Full queue: no push. This holds even if `print_ack` pops in the same cycle (full blocks push unconditionally). Requesters stay pending.
- Pop: when `print_hex_enable && print_ack`. `print_ack` while empty is ignored.
- Simultaneous push and pop (queue not full): occupancy unchanged; data order preserved.
- Queue: circular buffer with read/write pointers of width `$clog2(FIFO_DEPTH)`, wrapping naturally; `fifo_level` is a separate counter.
- Head outputs (`print_output`, `print_core_id`) come from `mem[rd_ptr]`. Their value is don't-care while `print_hex_enable` is 0.
- `NUM_CORES == 1`: degenerates to a buffered single-core arbiter; `print_core_id` is always 0.

## Timing
- Reset values:
  - `is_ready_core = 0`, `print_hex_enable = 0`, `fifo_level = 0`;
  - `print_output = 0`, `print_core_id = 0`;
  - pointers 0; `last_grant = NUM_CORES-1`.
- Reset asserted mid-operation: queue contents and pending acks are discarded immediately. No `is_ready_core` pulse is issued for a word caught in flight. Cores are reset alongside.
- Latency with an empty queue:
  - `req_core[i]` rises in cycle T;
  - in T+1, `is_ready_core[i]=1`, `print_hex_enable=1` and the head holds the data;
  - earliest pop is in T+1 via `print_ack`.
- Per-core throughput: at most one accept every 2 cycles (ack-cycle mask). The aggregate can reach 1 word/cycle when ≥2 cores are requesting.
- `fifo_level` and `print_hex_enable` are registered, updating on the edge that performs the push or pop.
- Fairness bound: a requesting core waits at most `NUM_CORES-1` grants of other cores, counted while the queue is not full.

## Test plan
- Single request, NUM_CORES=2:
  - Stimulus: core0 requests 0xDEADBEEF in cycle 5, `print_ack` tied 1.
  - Required: `is_ready_core=2'b01` and `print_hex_enable=1`, `print_output=0xDEADBEEF`, `print_core_id=0` in cycle 6; level back to 0 in cycle 7; no second accept while `req_core[0]` is still high in cycle 6.
- Round-robin, NUM_CORES=4:
  - Stimulus: all cores request continuously with data 0x10+i, `print_ack=1`, each core re-requesting after its ack.
  - Required: `print_core_id` sequence 0,1,2,3,0,1…; no core is granted twice before all others have been granted.
- Full queue, FIFO_DEPTH=4:
  - Stimulus: `print_ack=0`, cores 0 and 1 request repeatedly.
  - Required: `fifo_level` reaches 4 and then stops; no `is_ready_core` pulse while full; `print_ack=1` with a requester pending gives a pop that cycle, with no push in the same cycle and a push the next cycle.
- Pointer wrap:
  - Stimulus: push/pop 10 words 0x1..0xA through depth 4 with a random `print_ack`.
  - Required: output order is exactly 0x1..0xA; `fifo_level` never exceeds 4.
- Async reset mid-operation:
  - Stimulus: queue holding 3 words, assert `reset` between clock edges.
  - Required: outputs return to their reset values immediately; after release, core0 has first priority.

Source files
------------

// File: rtl/print_output_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : print_output_arbiter_n
// Purpose  : Round-robin arbiter for NUM_CORES hex-print requesters feeding a
//            core-ID-tagged FIFO drained by chip_controller (valid/ack).
// Revision : 1.0 - initial release
// ============================================================================
module print_output_arbiter_n #(
  parameter int NUM_CORES  = 2,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req_core,
  input  logic [NUM_CORES*DATA_W-1:0] data_core,
  output logic [NUM_CORES-1:0]        is_ready_core,
  output logic                        print_hex_enable,
  output logic [DATA_W-1:0]           print_output,
  output logic [ID_W-1:0]             print_core_id,
  input  logic                        print_ack,
  output logic [CNT_W-1:0]            fifo_level
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_ent_w = ID_W + DATA_W;

  logic [c_ent_w-1:0]   r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]     r_level;
  logic                 r_hex_en;
  logic [NUM_CORES-1:0] r_ready;
  logic [ID_W-1:0]      r_last_grant;

  logic [NUM_CORES-1:0] w_elig;
  logic [ID_W-1:0]      w_cand;
  logic [ID_W-1:0]      w_grant;
  logic                 w_grant_valid;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [CNT_W-1:0]     w_level_nxt;
  logic [c_ent_w-1:0]   w_head;

  // A core is masked in its own ack cycle so a held request is not taken twice
  assign w_elig = req_core & ~r_ready;

  // Walk offsets from farthest to nearest so the nearest eligible core wins
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_cand        = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      w_cand = ID_W'((int'(r_last_grant) + k) % NUM_CORES);
      if (w_elig[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant       = w_cand;
      end
    end
  end

  assign w_full = (r_level == CNT_W'(FIFO_DEPTH));
  assign w_push = w_grant_valid && !w_full;
  assign w_pop  = r_hex_en && print_ack;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + CNT_W'(1);
      2'b01:   w_level_nxt = r_level - CNT_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_hex_en     <= 1'b0;
      r_ready      <= '0;
      r_last_grant <= ID_W'(NUM_CORES - 1);
    end else begin
      r_ready <= '0;
      if (w_push) begin
        r_wr_ptr         <= r_wr_ptr + c_ptr_w'(1);
        r_last_grant     <= w_grant;
        r_ready[w_grant] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_level  <= w_level_nxt;
      r_hex_en <= (w_level_nxt != '0);
    end
  end

  // Storage needs no reset; the head is gated to zero while the queue is empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_grant, data_core[int'(w_grant)*DATA_W +: DATA_W]};
    end
  end

  assign w_head           = r_hex_en ? r_mem[r_rd_ptr] : '0;
  assign print_output     = w_head[DATA_W-1:0];
  assign print_core_id    = w_head[c_ent_w-1:DATA_W];
  assign print_hex_enable = r_hex_en;
  assign fifo_level       = r_level;
  assign is_ready_core    = r_ready;

endmodule
`default_nettype wire
